// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: shares one UART transmitter between two 9-bit frame
// sources. Each source has a one-entry hold buffer. A four-state FSM moves
// buffered frames into the transmitter over a start/busy handshake.
// Arbitration is round-robin, or fixed to requester 1 while debug is high.
module uart_frame_arbiter #(
    parameter int FRAME_W      = 9,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active low
    input  logic               debug,
    input  logic [FRAME_W-1:0] frame0,
    input  logic               frame0_valid,
    input  logic [FRAME_W-1:0] frame1,
    input  logic               frame1_valid,
    input  logic               tx_busy,
    output logic [FRAME_W-1:0] tx_frame,
    output logic               tx_start,
    output logic               full0,
    output logic               full1,
    output logic               overflow0,
    output logic               overflow1,
    output logic               timeout,
    output logic               grant
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     grant_q, grant_d;
    logic [FRAME_W-1:0]       tx_frame_q, tx_frame_d;
    logic                     timeout_q, timeout_d;
    logic [1:0][FRAME_W-1:0]  buf_q, buf_d;
    logic [1:0]               full_q, full_d;
    logic [1:0]               ovf_q, ovf_d;

    logic [1:0][FRAME_W-1:0]  frm_in;
    logic [1:0]               vld_in;
    logic [1:0]               free;
    logic                     win;

    assign frm_in = {frame1, frame0};
    assign vld_in = {frame1_valid, frame0_valid};

    // State and datapath registers; reset discards any buffered frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            tx_frame_q <= '0;
            timeout_q  <= 1'b0;
            buf_q      <= '0;
            full_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            tx_frame_q <= tx_frame_d;
            timeout_q  <= timeout_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: winner selection in IDLE, busy handshake and timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        tx_frame_d = tx_frame_q;
        timeout_d  = timeout_q;
        // Requester 1 wins when debug and full1; with both full in normal
        // mode the one not served last wins; otherwise whichever is full.
        if (debug)
            win = full_q[1];
        else if (&full_q)
            win = ~grant_q;
        else
            win = full_q[1];
        case (state_q)
            IDLE: begin
                if (|full_q) begin
                    grant_d    = win;
                    tx_frame_d = buf_q[win];
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Frame is abandoned, not retried
                    if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: start pulse and release of the granted buffer in START
    always_comb begin
        tx_start = (state_q == START);
        free     = '0;
        free[grant_q] = (state_q == START);
    end

    // Hold buffers: load when empty or being freed this cycle, else overflow
    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        for (int n = 0; n < 2; n++) begin
            if (vld_in[n]) begin
                if (!full_q[n] || free[n]) begin
                    buf_d[n]  = frm_in[n];
                    full_d[n] = 1'b1;
                end else begin
                    ovf_d[n] = 1'b1;
                end
            end else if (free[n]) begin
                full_d[n] = 1'b0;
            end
        end
    end

    assign tx_frame  = tx_frame_q;
    assign full0     = full_q[0];
    assign full1     = full_q[1];
    assign overflow0 = ovf_q[0];
    assign overflow1 = ovf_q[1];
    assign timeout   = timeout_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: directed scenarios plus a randomized phase.
// A transaction-level model predicts every output each cycle.
module tb_uart_frame_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug = 1'b0;
    logic [8:0] frame0 = '0, frame1 = '0;
    logic       frame0_valid = 1'b0, frame1_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [8:0] tx_frame;
    logic       tx_start, full0, full1, overflow0, overflow1, timeout, grant;

    always #5 clk = ~clk;

    uart_frame_arbiter #(.FRAME_W(9), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .debug(debug),
        .frame0(frame0), .frame0_valid(frame0_valid),
        .frame1(frame1), .frame1_valid(frame1_valid),
        .tx_busy(tx_busy), .tx_frame(tx_frame), .tx_start(tx_start),
        .full0(full0), .full1(full1), .overflow0(overflow0),
        .overflow1(overflow1), .timeout(timeout), .grant(grant)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_full[2];
    logic [8:0] m_buf[2];
    bit         m_ovf[2];
    bit         m_to, m_grant;
    logic [8:0] m_txf;
    bit         m_active;   // a frame has been chosen and is in flight
    bit         m_pend;     // chosen frame not yet started (start pulse now)
    bit         m_seen;     // transmitter acknowledged with busy
    int         m_waited;

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_buf[i] = '0; m_ovf[i] = 0;
        end
        m_to = 0; m_grant = 0; m_txf = '0;
        m_active = 0; m_pend = 0; m_seen = 0; m_waited = 0;
    endfunction

    function automatic void m_step();
        bit         v[2];
        logic [8:0] f[2];
        bit         fr, g_old, w;
        v[0] = frame0_valid; v[1] = frame1_valid;
        f[0] = frame0;       f[1] = frame1;
        fr    = m_active && m_pend;
        g_old = m_grant;
        if (!m_active) begin
            if (m_full[0] || m_full[1]) begin
                if (debug)                      w = m_full[1];
                else if (m_full[0] && m_full[1]) w = !m_grant;
                else                            w = m_full[1];
                m_grant = w; m_txf = m_buf[w];
                m_active = 1; m_pend = 1;
            end
        end else if (m_pend) begin
            m_pend = 0; m_waited = 0; m_seen = 0;
        end else if (!m_seen) begin
            if (tx_busy) m_seen = 1;
            else begin
                m_waited++;
                if (m_waited == TO) begin m_to = 1; m_active = 0; end
            end
        end else if (!tx_busy) begin
            m_active = 0;
        end
        for (int n = 0; n < 2; n++) begin
            if (v[n]) begin
                if (!m_full[n] || (fr && g_old == n[0])) begin
                    m_buf[n] = f[n]; m_full[n] = 1;
                end else m_ovf[n] = 1;
            end else if (fr && g_old == n[0]) m_full[n] = 0;
        end
    endfunction

    // ---------------- transmitter model ----------------
    int  x_delay = 2, x_len = 10, x_wait = 0, x_left = 0;
    bit  x_never = 0, x_rand = 0, xm_busy = 0;
    bit  st_seen;
    logic [8:0] sent[$];

    task automatic cycle();
        @(negedge clk);
        chk("outs", {16'h0, tx_frame, tx_start, full1, full0, overflow1, overflow0, timeout, grant},
                    {16'h0, m_txf, m_active && m_pend, m_full[1], m_full[0], m_ovf[1], m_ovf[0], m_to, m_grant});
        st_seen = tx_start;
        if (tx_start) sent.push_back(tx_frame);
        @(posedge clk);
        if (rst) m_step(); else m_reset();
        #1;
        frame0_valid = 0; frame1_valid = 0;
        if (x_rand && st_seen) begin
            x_delay = $urandom_range(1, 4);
            x_len   = $urandom_range(1, 8);
            x_never = ($urandom_range(0, 9) == 0);
        end
        if (xm_busy) begin
            x_left--;
            if (x_left == 0) xm_busy = 0;
        end else if (x_wait > 0) begin
            x_wait--;
            if (x_wait == 0) begin xm_busy = 1; x_left = x_len; end
        end
        if (st_seen && !x_never) begin
            if (x_delay == 1) begin xm_busy = 1; x_left = x_len; end
            else x_wait = x_delay - 1;
        end
        if (!rst) begin xm_busy = 0; x_wait = 0; end
        tx_busy = xm_busy | (x_rand && ($urandom_range(0, 9) == 0));
    endtask

    task automatic do_reset(input int n);
        rst = 0; m_reset(); xm_busy = 0; x_wait = 0; sent.delete();
        repeat (n) begin
            frame0 = 9'($urandom); frame1 = 9'($urandom);
            frame0_valid = 1'($urandom); frame1_valid = 1'($urandom);
            debug = 1'($urandom);
            cycle();
            tx_busy = 1'($urandom);
        end
        rst = 1; frame0_valid = 0; frame1_valid = 0; debug = 0; tx_busy = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0, guard;
        rst = 1;
        #1 rst = 0;
        // Reset with random inputs, then idle
        do_reset(5);
        repeat (50) cycle();
        chk("idle_starts", sent.size(), 0);

        // Single frame
        x_delay = 2; x_len = 10;
        frame0 = 9'h0AA; frame0_valid = 1; cycle();
        repeat (20) cycle();
        chk("single_n", sent.size(), 1);
        chk("single_frm", (sent.size() > 0) ? sent[0] : 9'h1FF, 9'h0AA);
        chk("single_full0", full0, 0);
        chk("single_grant", grant, 0);

        // Round-robin with simultaneous strobes, grant=0 beforehand
        sent.delete(); debug = 0;
        frame0 = 9'h155; frame1 = 9'h0B3; frame0_valid = 1; frame1_valid = 1;
        cycle();
        repeat (40) cycle();
        chk("rr_n", sent.size(), 2);
        chk("rr_first", (sent.size() > 1) ? sent[0] : 9'h1FF, 9'h0B3);
        chk("rr_second", (sent.size() > 1) ? sent[1] : 9'h1FF, 9'h155);
        chk("rr_grant", grant, 0);

        // Debug priority with requester 1 kept full
        sent.delete(); debug = 1; x_len = 4; k = 0;
        frame0 = 9'h0C0; frame0_valid = 1;
        repeat (60) begin
            if (!m_full[1] || (m_active && m_pend && m_grant)) begin
                frame1 = 9'h100 | 9'(k); frame1_valid = 1; k++;
            end
            cycle();
        end
        n0 = 0;
        foreach (sent[i]) if (!sent[i][8]) n0++;
        chk("dbg_req0_held", n0, 0);
        chk("dbg_req1_sent", sent.size() >= 3, 1);
        repeat (40) cycle();
        n0 = 0;
        foreach (sent[i]) if (!sent[i][8]) n0++;
        chk("dbg_req0_once", n0, 1);
        chk("dbg_last", (sent.size() > 0) ? sent[sent.size()-1] : 9'h1FF, 9'h0C0);

        // Overflow while a transfer is in progress
        do_reset(2); x_len = 12;
        frame0 = 9'h011; frame0_valid = 1; cycle();
        repeat (3) cycle();
        frame0 = 9'h022; frame0_valid = 1; cycle();
        frame0 = 9'h033; frame0_valid = 1; cycle();
        chk("ovf_set", overflow0, 1);
        repeat (40) cycle();
        chk("ovf_n", sent.size(), 2);
        chk("ovf_kept", (sent.size() > 1) ? sent[1] : 9'h1FF, 9'h022);

        // Strobe in the START cycle is accepted without overflow
        do_reset(2); x_len = 5;
        frame0 = 9'h0A1; frame0_valid = 1; cycle();
        guard = 0;
        while (!(m_active && m_pend) && guard < 20) begin cycle(); guard++; end
        chk("start_found", guard < 20, 1);
        frame0 = 9'h0A2; frame0_valid = 1; cycle();
        chk("same_cyc_ovf", overflow0, 0);
        chk("same_cyc_full", full0, 1);
        repeat (40) cycle();
        chk("same_cyc_n", sent.size(), 2);
        chk("same_cyc_frm", (sent.size() > 1) ? sent[1] : 9'h1FF, 9'h0A2);

        // Timeout when busy never rises
        do_reset(2); x_never = 1;
        frame0 = 9'h0C3; frame0_valid = 1; cycle();
        repeat (17) cycle();
        chk("to_early", timeout, 0);
        repeat (3) cycle();
        chk("to_set", timeout, 1);
        x_never = 0;
        frame0 = 9'h0C4; frame0_valid = 1; cycle();
        repeat (30) cycle();
        chk("to_recover_n", sent.size(), 2);
        chk("to_sticky", timeout, 1);

        // Asynchronous reset during WAIT_DONE
        x_len = 10;
        frame1 = 9'h1D1; frame1_valid = 1; cycle();
        guard = 0;
        while (!(m_active && m_seen) && guard < 30) begin cycle(); guard++; end
        chk("done_found", guard < 30, 1);
        rst = 0; m_reset(); xm_busy = 0; x_wait = 0; tx_busy = 0;
        #1;
        chk("rst_mid", {16'h0, tx_frame, tx_start, full1, full0, overflow1, overflow0, timeout, grant}, 0);
        cycle();
        rst = 1;
        repeat (10) cycle();

        // Randomized traffic
        do_reset(3); x_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1499) == 0) do_reset(2);
            if ($urandom_range(0, 49) == 0) debug = ~debug;
            frame0 = 9'($urandom); frame1 = 9'($urandom);
            frame0_valid = ($urandom_range(0, 5) == 0);
            frame1_valid = ($urandom_range(0, 5) == 0);
            cycle();
        end
        x_rand = 0; x_never = 0;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Shares the single UART transmitter in the VGA debug path between two 9-bit frame sources.
  - Requester 0: application/status frames.
  - Requester 1: debug-echo frames from the UART debug interface.
- Each requester has a one-entry hold buffer.
- The arbiter serialises buffered frames into the transmitter using a start/busy handshake.
- Priority is round-robin in normal mode and fixed to requester 1 when debug is asserted.

Parameters:
- FRAME_W, 9, frame width in bits.
- BUSY_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start before the transfer is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- debug  in  1  1 = fixed priority to requester 1.
- frame0  in  FRAME_W  requester 0 frame data.
- frame0_valid  in  1  one-cycle strobe; frame0 is captured on this cycle.
- frame1  in  FRAME_W  requester 1 (debug) frame data.
- frame1_valid  in  1  one-cycle strobe for frame1.
- tx_busy  in  1  transmitter busy, high for the whole transmission.
- tx_frame  out  FRAME_W  frame presented to the transmitter; held stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle start pulse.
- full0, full1  out  1  hold buffer n occupied.
- overflow0, overflow1  out  1  sticky; a strobe arrived while buffer n was full and not being freed this cycle.
- timeout  out  1  sticky; a transfer was abandoned on timeout.
- grant  out  1  index of the requester last or currently served.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_frame=0, tx_start=0, full0=full1=0, overflow*=0, timeout=0, grant=0.
  - FSM enters IDLE and the timeout counter is cleared.
  - Frames captured before reset are discarded.
  - tx_busy is ignored until IDLE.
- Buffer capture:
  - A valid strobe with buffer empty loads the buffer and sets full on the next edge.
  - A strobe on a full buffer keeps the old frame and sets overflow.
  - Exception: a strobe arriving in the same cycle the buffer is freed (the START cycle) is accepted, full stays 1 and overflow is not set.
- FSM states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: if any full, select a winner, latch it into tx_frame, update grant, go to START.
    - debug=1: requester 1 wins if full1, else requester 0.
    - debug=0: round-robin; when both are full, the winner is the one not equal to grant.
  - START: tx_start=1 for exactly one cycle; the winner's buffer is freed (full cleared) at this edge; counter cleared; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1 -> go to WAIT_DONE.
    - Otherwise the counter increments; at BUSY_TIMEOUT, set timeout and return to IDLE. The frame is lost, not retried.
  - WAIT_DONE: tx_busy=0 -> IDLE.
- Latency: buffer write at edge N, FSM in IDLE -> tx_start high in cycle N+2. Minimum spacing between starts is 4 cycles plus tx_busy duration.
- A change of debug takes effect at the next IDLE decision only; it never aborts a transfer.
- tx_busy high while in IDLE is ignored; arbitration proceeds.
- Overflow and timeout clear only on reset.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0; release, no strobes -> tx_start stays 0 for 50 cycles.
- Single frame: frame0=9'h0AA strobe, transmitter model asserts tx_busy 2 cycles after start for 10 cycles -> one tx_start, tx_frame=9'h0AA held until busy falls, full0 back to 0, grant=0.
- Round-robin: debug=0, both strobed in the same cycle (9'h155, 9'h0B3), grant=0 beforehand -> order 9'h0B3 (req1) then 9'h155, then grant=0.
- Debug priority: debug=1, req0 and req1 continuously refilled -> only req1 frames sent while full1; req0 frame sent once req1 is idle.
- Overflow: two frame0 strobes while a transfer occupies the FSM and full0=1 -> overflow0=1, first frame transmitted, second dropped; same-cycle-as-START strobe accepted without overflow.
- Timeout and reset mid-operation: tx_busy never rises -> timeout=1 after 16 cycles in WAIT_BUSY, FSM returns to IDLE; rst=0 during WAIT_DONE -> immediate IDLE and all outputs 0.
